cache_mem_arbiter: RTL and testbench

- Arbitrates the single memory request port between i_cache and d_cache; sits directly downstream of both caches and upstream of the AXI interface.
- Replaces the combinational cache-miss select with a registered, grant-locked arbiter.
- Data requests take priority over instruction requests, with a bounded-starvation guarantee for instruction fetch.
- Request fields are latched at grant, so they stay stable for the whole AXI transaction.

---
 rtl/cache_mem_arbiter_pkg.sv | 42 ++++
 rtl/cache_mem_arbiter.sv | 109 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache memory-port definitions: arbiter state codes, transfer size codes
// and the latched memory request layout.
package cache_mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      BUSY_I = ST_BUSY_I,
      BUSY_D = ST_BUSY_D,
      DONE   = ST_DONE
   } arb_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] SEL_WORD = 4'b1111;

   typedef struct packed {
      logic [31:0] a;
      logic        write;
      logic [1:0]  size;
      logic [3:0]  sel;
      logic [31:0] st_data;
   } mem_req_t;

   // Instruction fetches are always full-word reads.
   function automatic mem_req_t ifetch_req(input logic [31:0] a);
      mem_req_t r;
      r.a       = a;
      r.write   = 1'b0;
      r.size    = SZ_WORD;
      r.sel     = SEL_WORD;
      r.st_data = 32'h0;
      return r;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Grant-locked arbiter for the shared memory port: D-cache has priority, I-cache
// is forced through after STARVE_MAX consecutive contended D grants.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] i_a,
   input  logic        i_strobe,
   output logic        i_ready,
   output logic [31:0] i_data,
   input  logic [31:0] d_a,
   input  logic        d_strobe,
   input  logic        d_rw,
   input  logic [1:0]  d_size,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_st_data,
   output logic        d_ready,
   output logic [31:0] d_data,
   output logic [31:0] mem_a,
   output logic        mem_access,
   output logic        mem_write,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_st_data,
   input  logic [31:0] mem_data,
   input  logic        mem_ready
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_e       state, state_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   mem_req_t         req_q, req_nxt;
   logic             access_nxt;
   logic             grant_i, grant_d;

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      req_nxt    = req_q;
      access_nxt = mem_access;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            grant_i = i_strobe & (~d_strobe | (starve_cnt == STARVE_LIM));
            grant_d = d_strobe & ~grant_i;
            if (grant_i) begin
               state_nxt  = BUSY_I;
               access_nxt = 1'b1;
               req_nxt    = ifetch_req(i_a);
               starve_nxt = '0;
            end else if (grant_d) begin
               state_nxt       = BUSY_D;
               access_nxt      = 1'b1;
               req_nxt.a       = d_a;
               req_nxt.write   = d_rw;
               req_nxt.size    = d_size;
               req_nxt.sel     = d_sel;
               req_nxt.st_data = d_st_data;
               // Only a D grant that actually blocked a waiting I fetch counts.
               if (!i_strobe)
                  starve_nxt = '0;
               else if (starve_cnt != STARVE_LIM)
                  starve_nxt = starve_cnt + 1'b1;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               state_nxt  = DONE;
               access_nxt = 1'b0;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         starve_cnt <= '0;
         req_q      <= '0;
         mem_access <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         req_q      <= req_nxt;
         mem_access <= access_nxt;
      end
   end

   assign mem_a       = req_q.a;
   assign mem_write   = req_q.write;
   assign mem_size    = req_q.size;
   assign mem_sel     = req_q.sel;
   assign mem_st_data = req_q.st_data;

   // Completion is steered to the owner in the same cycle mem_ready arrives.
   assign i_ready = mem_ready & (state == BUSY_I);
   assign d_ready = mem_ready & (state == BUSY_D);
   assign i_data  = mem_data;
   assign d_data  = mem_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected grants and completions are
// queued as requests are driven and retired by a negedge monitor.
module tb_cache_mem_arbiter;

   typedef struct packed {
      logic [31:0] a;
      logic        write;
      logic [1:0]  size;
      logic [3:0]  sel;
      logic [31:0] st_data;
   } grant_t;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } rdy_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] i_a;
   logic        i_strobe;
   logic        i_ready;
   logic [31:0] i_data;
   logic [31:0] d_a;
   logic        d_strobe;
   logic        d_rw;
   logic [1:0]  d_size;
   logic [3:0]  d_sel;
   logic [31:0] d_st_data;
   logic        d_ready;
   logic [31:0] d_data;
   logic [31:0] mem_a;
   logic        mem_access;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic [3:0]  mem_sel;
   logic [31:0] mem_st_data;
   logic [31:0] mem_data;
   logic        mem_ready;

   logic        resp_ready = 1'b0;
   logic [31:0] resp_data  = 32'h0;
   logic        spur_ready = 1'b0;
   logic [31:0] spur_data  = 32'h0;
   assign mem_ready = resp_ready | spur_ready;
   assign mem_data  = spur_ready ? spur_data : resp_data;

   int checks = 0;
   int errors = 0;
   int n_irdy = 0;
   int n_drdy = 0;
   int last_gap = 0;
   int resp_lat = 3;

   grant_t      exp_g[$];
   rdy_t        exp_r[$];
   logic [31:0] rdata_q[$];

   always #5 clk = ~clk;

   cache_mem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
      .clk(clk), .resetn(resetn),
      .i_a(i_a), .i_strobe(i_strobe), .i_ready(i_ready), .i_data(i_data),
      .d_a(d_a), .d_strobe(d_strobe), .d_rw(d_rw), .d_size(d_size), .d_sel(d_sel),
      .d_st_data(d_st_data), .d_ready(d_ready), .d_data(d_data),
      .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
      .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_data(mem_data), .mem_ready(mem_ready)
   );

   // Memory model: completes each access resp_lat cycles after it is first seen.
   initial begin
      bit rbusy;
      int rcnt;
      rbusy = 1'b0;
      rcnt  = 0;
      forever begin
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         if (!resetn) begin
            rbusy = 1'b0;
         end else if (mem_access) begin
            if (!rbusy) begin
               rbusy = 1'b1;
               rcnt  = 0;
            end
            rcnt++;
            if (rcnt == resp_lat) begin
               resp_ready = 1'b1;
               if (rdata_q.size() != 0) resp_data = rdata_q.pop_front();
               else                     resp_data = 32'hFFFF_FFFF;
            end
         end else begin
            rbusy = 1'b0;
         end
      end
   end

   // Monitor: retires grants and completions against the scoreboard queues.
   initial begin
      logic   prev_acc;
      int     low_cyc;
      grant_t held, cur, g;
      rdy_t   e;
      prev_acc = 1'b0;
      low_cyc  = 100;
      held     = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_acc = 1'b0;
            low_cyc  = 100;
         end else begin
            cur = {mem_a, mem_write, mem_size, mem_sel, mem_st_data};
            if (i_ready || d_ready) begin
               checks++;
               if (i_ready && d_ready) begin
                  errors++;
                  $display("FAIL ready_both: i_ready=%b d_ready=%b, need one-hot", i_ready, d_ready);
               end else if (exp_r.size() == 0) begin
                  errors++;
                  $display("FAIL ready_unexpected: i_ready=%b d_ready=%b, none expected", i_ready, d_ready);
               end else begin
                  e = exp_r.pop_front();
                  if (d_ready !== e.is_d || (d_ready ? d_data : i_data) !== e.data) begin
                     errors++;
                     $display("FAIL ready_data: got d_ready=%b data=%h, need is_d=%b data=%h",
                              d_ready, d_ready ? d_data : i_data, e.is_d, e.data);
                  end
               end
               if (i_ready) n_irdy++;
               if (d_ready) n_drdy++;
            end
            if (mem_access && !prev_acc) begin
               checks++;
               last_gap = low_cyc;
               held     = cur;
               if (exp_g.size() == 0) begin
                  errors++;
                  $display("FAIL grant_unexpected: got %h, none expected", cur);
               end else begin
                  g = exp_g.pop_front();
                  if (cur !== g) begin
                     errors++;
                     $display("FAIL grant_fields: got %h, need %h", cur, g);
                  end
               end
               checks++;
               if (low_cyc < 2) begin
                  errors++;
                  $display("FAIL grant_gap: idle cycles %0d, need >= 2", low_cyc);
               end
            end else if (mem_access) begin
               checks++;
               if (cur !== held) begin
                  errors++;
                  $display("FAIL hold_fields: got %h, need %h", cur, held);
               end
            end
            low_cyc  = mem_access ? 0 : low_cyc + 1;
            prev_acc = mem_access;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input int want_i, input int want_d, input string tag);
      int b = 0;
      while ((n_irdy < want_i || n_drdy < want_d) && b < 200) begin
         tick();
         b++;
      end
      checks++;
      if (n_irdy < want_i || n_drdy < want_d) begin
         errors++;
         $display("FAIL %s_timeout: i/d ready counts %0d/%0d, need %0d/%0d",
                  tag, n_irdy, n_drdy, want_i, want_d);
      end
   endtask

   task automatic exp_i(input logic [31:0] a, input logic [31:0] rd);
      exp_g.push_back({a, 1'b0, 2'b10, 4'b1111, 32'h0});
      exp_r.push_back({1'b0, rd});
      rdata_q.push_back(rd);
   endtask

   task automatic exp_d(input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic [3:0] sel, input logic [31:0] st, input logic [31:0] rd);
      exp_g.push_back({a, w, sz, sel, st});
      exp_r.push_back({1'b1, rd});
      rdata_q.push_back(rd);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_access, mem_write, i_ready, d_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: access/write/i_rdy/d_rdy=%b, need 0000",
                  {mem_access, mem_write, i_ready, d_ready});
      end
      checks++;
      if ({mem_a, mem_size, mem_sel, mem_st_data} !== 70'h0) begin
         errors++;
         $display("FAIL reset_fields: got %h, need 0", {mem_a, mem_size, mem_sel, mem_st_data});
      end
      @(posedge clk);
      #1 resetn = 1'b1;
      tick();
   endtask

   task automatic test_single_i();
      int ni0 = n_irdy;
      int nd0 = n_drdy;
      exp_i(32'hBFC0_0000, 32'h3C1D_0001);
      i_a      = 32'hBFC0_0000;
      i_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_access !== 1'b1 || mem_size !== 2'b10 || mem_sel !== 4'b1111) begin
         errors++;
         $display("FAIL single_i_latency: access=%b size=%b sel=%b, need 1 10 1111",
                  mem_access, mem_size, mem_sel);
      end
      wait_rdy(ni0 + 1, nd0, "single_i");
      i_strobe = 1'b0;
      repeat (3) tick();
      checks++;
      if (n_irdy !== ni0 + 1 || n_drdy !== nd0) begin
         errors++;
         $display("FAIL single_i_pulses: i/d pulses %0d/%0d, need 1/0", n_irdy - ni0, n_drdy - nd0);
      end
   endtask

   task automatic test_simultaneous();
      int ni0 = n_irdy;
      int nd0 = n_drdy;
      exp_d(32'h8000_1000, 1'b1, 2'b01, 4'b0011, 32'hDEAD_BEEF, 32'h1111_2222);
      exp_i(32'h0040_0010, 32'h2400_0001);
      d_a = 32'h8000_1000; d_rw = 1'b1; d_size = 2'b01; d_sel = 4'b0011;
      d_st_data = 32'hDEAD_BEEF; i_a = 32'h0040_0010;
      d_strobe = 1'b1;
      i_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b1 || mem_sel !== 4'b0011 || mem_st_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL simul_d_first: write=%b sel=%b st=%h, need 1 0011 deadbeef",
                  mem_write, mem_sel, mem_st_data);
      end
      wait_rdy(ni0, nd0 + 1, "simul_d");
      d_strobe = 1'b0;
      checks++;
      if (n_irdy !== ni0) begin
         errors++;
         $display("FAIL simul_order: i served %0d before d, need 0", n_irdy - ni0);
      end
      wait_rdy(ni0 + 1, nd0 + 1, "simul_i");
      i_strobe = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      int          ni0  = n_irdy;
      int          nd0  = n_drdy;
      logic [31:0] base = 32'h8000_2000;
      for (int k = 0; k < 4; k++)
         exp_d(base + 32'(4 * k), 1'b0, 2'b10, 4'b1111, 32'h5555_AAAA, 32'hD000_0000 + 32'(k));
      exp_i(32'h0040_0100, 32'h1000_0100);
      exp_d(base + 32'd16, 1'b0, 2'b10, 4'b1111, 32'h5555_AAAA, 32'hD000_0004);
      d_a = base; d_rw = 1'b0; d_size = 2'b10; d_sel = 4'b1111; d_st_data = 32'h5555_AAAA;
      i_a = 32'h0040_0100;
      i_strobe = 1'b1;
      d_strobe = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wait_rdy(ni0, nd0 + k, "starve_d");
         d_a = base + 32'(4 * k);
      end
      checks++;
      if (n_irdy !== ni0) begin
         errors++;
         $display("FAIL starve_early_i: i served %0d during first 4 d grants, need 0", n_irdy - ni0);
      end
      wait_rdy(ni0 + 1, nd0 + 4, "starve_i");
      checks++;
      if (last_gap !== 2) begin
         errors++;
         $display("FAIL starve_back_to_back: gap %0d, need 2", last_gap);
      end
      wait_rdy(ni0 + 1, nd0 + 5, "starve_after");
      i_strobe = 1'b0;
      d_strobe = 1'b0;
      tick();
   endtask

   task automatic test_field_stability();
      int nd0 = n_drdy;
      resp_lat = 6;
      exp_d(32'h8000_3000, 1'b1, 2'b00, 4'b0100, 32'h00AB_0000, 32'h0000_0000);
      d_a = 32'h8000_3000; d_rw = 1'b1; d_size = 2'b00; d_sel = 4'b0100; d_st_data = 32'h00AB_0000;
      d_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tick();
      d_a = 32'h1234_5678; d_st_data = 32'hFFFF_FFFF; d_sel = 4'hF; d_rw = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_a !== 32'h8000_3000 || mem_st_data !== 32'h00AB_0000 || mem_write !== 1'b1) begin
         errors++;
         $display("FAIL stability: a=%h st=%h w=%b, need 80003000 00ab0000 1", mem_a, mem_st_data, mem_write);
      end
      wait_rdy(n_irdy, nd0 + 1, "stability");
      d_strobe = 1'b0;
      resp_lat = 3;
      tick();
   endtask

   task automatic test_spurious_stale();
      int nd0 = n_drdy;
      spur_data  = 32'hCAFE_0000;
      spur_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
         errors++;
         $display("FAIL spurious_ready: i=%b d=%b, need 0 0", i_ready, d_ready);
      end
      tick();
      spur_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_access !== 1'b0) begin
         errors++;
         $display("FAIL spurious_access: got %b, need 0", mem_access);
      end
      exp_d(32'h8000_4000, 1'b0, 2'b10, 4'b1111, 32'h0, 32'h7777_0001);
      d_a = 32'h8000_4000; d_rw = 1'b0; d_size = 2'b10; d_sel = 4'b1111; d_st_data = 32'h0;
      d_strobe = 1'b1;
      wait_rdy(n_irdy, nd0 + 1, "stale");
      tick();
      d_strobe = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_access !== 1'b0) begin
         errors++;
         $display("FAIL stale_done_grant: access=%b after done, need 0", mem_access);
      end
      tick();
      @(negedge clk);
      checks++;
      if (mem_access !== 1'b0) begin
         errors++;
         $display("FAIL stale_idle_grant: access=%b, need 0", mem_access);
      end
   endtask

   task automatic test_reset_mid();
      int ni0, nd0;
      tick();
      resp_lat = 8;
      exp_d(32'h8000_5000, 1'b1, 2'b10, 4'b1111, 32'h0102_0304, 32'h0);
      d_a = 32'h8000_5000; d_rw = 1'b1; d_size = 2'b10; d_sel = 4'b1111; d_st_data = 32'h0102_0304;
      d_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({mem_access, mem_write, d_ready, mem_a, mem_size, mem_sel, mem_st_data} !== 73'h0) begin
         errors++;
         $display("FAIL reset_mid: access=%b a=%h st=%h, need all zero", mem_access, mem_a, mem_st_data);
      end
      d_strobe = 1'b0;
      exp_g.delete();
      exp_r.delete();
      rdata_q.delete();
      resp_lat = 3;
      @(posedge clk);
      #1 resetn = 1'b1;
      tick();
      ni0 = n_irdy;
      nd0 = n_drdy;
      exp_i(32'hBFC0_0010, 32'h8FBF_0010);
      i_a      = 32'hBFC0_0010;
      i_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_access !== 1'b1 || mem_a !== 32'hBFC0_0010) begin
         errors++;
         $display("FAIL reset_regrant: access=%b a=%h, need 1 bfc00010", mem_access, mem_a);
      end
      wait_rdy(ni0 + 1, nd0, "reset_i");
      i_strobe = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      resetn = 1'b0;
      i_a = '0; i_strobe = 1'b0;
      d_a = '0; d_strobe = 1'b0; d_rw = 1'b0; d_size = '0; d_sel = '0; d_st_data = '0;
      test_reset();
      test_single_i();
      test_simultaneous();
      test_starvation();
      test_field_stability();
      test_spurious_stale();
      test_reset_mid();
      checks++;
      if (exp_g.size() != 0 || exp_r.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d grants %0d completions outstanding, need 0 0",
                  exp_g.size(), exp_r.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
